// File: rtl/layer4_window_fetch_if.sv
// Read-side bus into the layer-3 result memory plus the tap stream toward the
// layer-4 MAC. The fetch block is the master of both halves.
interface layer4_window_fetch_if #(
  parameter int DATA_WIDTH = 128
);
  logic [15:0]           read_row_addr;
  logic [15:0]           read_col_addr;
  logic                  layer3_result_read_signal;
  logic [DATA_WIDTH-1:0] layer3_result_output;

  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [3:0]            win_kidx;
  logic [15:0]           win_row;
  logic [15:0]           win_col;
  logic                  win_last;

  modport master (
    output read_row_addr, read_col_addr, layer3_result_read_signal,
    input  layer3_result_output,
    output win_data, win_valid, win_kidx, win_row, win_col, win_last,
    input  win_ready
  );

  modport slave (
    input  read_row_addr, read_col_addr, layer3_result_read_signal,
    output layer3_result_output,
    input  win_data, win_valid, win_kidx, win_row, win_col, win_last,
    output win_ready
  );
endinterface

// File: rtl/layer4_window_fetch.sv
// Sweeps every KERNEL x KERNEL window of the layer-3 map, reads each tap from
// result memory and streams it, tagged, through a 2-entry buffer to the MAC.
module layer4_window_fetch #(
  parameter int MAP_WIDTH  = 14,
  parameter int KERNEL     = 3,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  layer4_window_fetch_if.master bus,
  output logic                  busy,
  output logic                  frame_done
);
  localparam logic [15:0] K_MAX = 16'(KERNEL - 1);
  localparam logic [15:0] W_MAX = 16'(MAP_WIDTH - KERNEL);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [3:0]  kidx;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tag_t                  tag;
  } entry_t;

  state_t      state_q, state_d;
  logic [15:0] kc_q, kc_d, kr_q, kr_d;
  logic [15:0] wc_q, wc_d, wr_q, wr_d;
  logic [15:0] row_addr_q, row_addr_d, col_addr_q, col_addr_d;
  tag_t        tag_q, tag_d;
  logic        inflight_q;
  entry_t      fifo_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  occ;
  logic        push, pop, issue, last_addr;
  entry_t      head;

  // Occupancy counts the read still in flight so a returning word always
  // finds a free slot even if the MAC stalls right after the strobe.
  assign push  = inflight_q;
  assign pop   = bus.win_valid & bus.win_ready;
  assign occ   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == RUN) && (occ < 3'(FIFO_DEPTH));
  assign cnt_d = cnt_q + 2'(push) - 2'(pop);

  assign last_addr = (kc_q == K_MAX) && (kr_q == K_MAX) &&
                     (wc_q == W_MAX) && (wr_q == W_MAX);

  assign row_addr_d = wr_q + kr_q;
  assign col_addr_d = wc_q + kc_q;

  always_comb begin
    tag_d      = '0;
    tag_d.kidx = 4'(kr_q * KERNEL + kc_q);
    tag_d.row  = wr_q;
    tag_d.col  = wc_q;
    tag_d.last = last_addr;
  end

  // k_c fastest, then k_r, win_col, win_row; the final win_row wrap leaves
  // every counter at zero ready for the next frame.
  always_comb begin
    kc_d = kc_q;
    kr_d = kr_q;
    wc_d = wc_q;
    wr_d = wr_q;
    if (state_q == IDLE && start) begin
      kc_d = '0;
      kr_d = '0;
      wc_d = '0;
      wr_d = '0;
    end else if (issue) begin
      if (kc_q == K_MAX) begin
        kc_d = '0;
        if (kr_q == K_MAX) begin
          kr_d = '0;
          if (wc_q == W_MAX) begin
            wc_d = '0;
            wr_d = (wr_q == W_MAX) ? 16'd0 : wr_q + 16'd1;
          end else begin
            wc_d = wc_q + 16'd1;
          end
        end else begin
          kr_d = kr_q + 16'd1;
        end
      end else begin
        kc_d = kc_q + 16'd1;
      end
    end
  end

  // DRAIN looks at next-cycle occupancy so DONE follows the final handshake
  // directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && last_addr) state_d = DRAIN;
      DRAIN:   if (cnt_d == 2'd0 && !issue) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      kc_q       <= '0;
      kr_q       <= '0;
      wc_q       <= '0;
      wr_q       <= '0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kc_d;
      kr_q       <= kr_d;
      wc_q       <= wc_d;
      wr_q       <= wr_d;
      inflight_q <= issue;
      cnt_q      <= cnt_d;
      if (issue) begin
        row_addr_q <= row_addr_d;
        col_addr_q <= col_addr_d;
        tag_q      <= tag_d;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.layer3_result_output, tag_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign bus.layer3_result_read_signal = issue;
  assign bus.read_row_addr = issue ? row_addr_d : row_addr_q;
  assign bus.read_col_addr = issue ? col_addr_d : col_addr_q;

  assign head          = fifo_q[rd_ptr_q];
  assign bus.win_valid = (cnt_q != 2'd0);
  assign bus.win_data  = head.data;
  assign bus.win_kidx  = head.tag.kidx;
  assign bus.win_row   = head.tag.row;
  assign bus.win_col   = head.tag.col;
  assign bus.win_last  = head.tag.last;

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);
endmodule

// File: tb/tb_layer4_window_fetch.sv
// Directed bench for layer4_window_fetch: memory model returns row*14+col in
// every channel; a scoreboard checks each strobe address and each tap.
module tb_layer4_window_fetch;
  logic clk = 1'b0;
  logic rst, start;
  logic busy, frame_done;

  layer4_window_fetch_if #(.DATA_WIDTH(128)) bus();

  layer4_window_fetch #(
    .MAP_WIDTH(14), .KERNEL(3), .DATA_WIDTH(128), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Read data is valid only the cycle after the strobe; otherwise junk.
  always @(posedge clk) begin
    if (bus.layer3_result_read_signal)
      bus.layer3_result_output <= {8{16'(int'(bus.read_row_addr) * 14 + int'(bus.read_col_addr))}};
    else
      bus.layer3_result_output <= {8{16'hDEAD}};
  end

  typedef struct {
    int tap;
    int prow;
    int pcol;
    int kidx;
  } vec_t;
  vec_t tbl [10];

  int checks = 0, errors = 0;
  int cyc, nstb, nhs, nlast, ndone, done_cyc, first_stb, last_stb, first_val;
  int first_busy, last_busy, stall_stb, max_out;
  logic stall_win, held_v;
  logic [164:0] held;
  int rec_pr [10], rec_pc [10], rec_k [10], rec_d [10];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [164:0] exp_tap(input int t);
    int kc, kr, wc, wr, pv;
    kc = t % 3; kr = (t / 3) % 3; wc = (t / 9) % 12; wr = t / 108;
    pv = (wr + kr) * 14 + (wc + kc);
    return {{8{16'(pv)}}, 4'(kr * 3 + kc), 16'(wr), 16'(wc), (t == 1295)};
  endfunction

  function automatic logic [31:0] exp_addr(input int t);
    int kc, kr, wc, wr;
    kc = t % 3; kr = (t / 3) % 3; wc = (t / 9) % 12; wr = t / 108;
    return {16'(wr + kr), 16'(wc + kc)};
  endfunction

  function automatic logic [164:0] cur_tap();
    return {bus.win_data, bus.win_kidx, bus.win_row, bus.win_col, bus.win_last};
  endfunction

  task automatic frame_init();
    cyc = 0; nstb = 0; nhs = 0; nlast = 0; ndone = 0; done_cyc = -1;
    first_stb = -1; last_stb = -1; first_val = -1; first_busy = -1; last_busy = -1;
    stall_stb = 0; max_out = 0; stall_win = 1'b0; held_v = 1'b0; held = '0;
  endtask

  task automatic mon();
    if (bus.layer3_result_read_signal) begin
      chk("rd_addr", 256'({bus.read_row_addr, bus.read_col_addr}), 256'(exp_addr(nstb)));
      if (first_stb < 0) first_stb = cyc;
      last_stb = cyc;
      if (stall_win) stall_stb++;
      nstb++;
    end
    if (busy) begin
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (frame_done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (bus.win_valid) begin
      if (first_val < 0) first_val = cyc;
      if (held_v) chk("stall_hold", 256'(cur_tap()), 256'(held));
      if (bus.win_ready) begin
        chk("tap", 256'(cur_tap()), 256'(exp_tap(nhs)));
        if (nhs < 10) begin
          rec_k[nhs]  = int'(bus.win_kidx);
          rec_pr[nhs] = int'(bus.win_row) + int'(bus.win_kidx) / 3;
          rec_pc[nhs] = int'(bus.win_col) + int'(bus.win_kidx) % 3;
          rec_d[nhs]  = int'(bus.win_data[15:0]);
        end
        if (bus.win_last) nlast++;
        nhs++;
      end
      held_v = !bus.win_ready;
      held   = cur_tap();
    end else begin
      if (held_v) chk("stall_valid_drop", 256'(bus.win_valid), 256'(1));
      held_v = 1'b0;
    end
    if (nstb - nhs > max_out) max_out = nstb - nhs;
  endtask

  task automatic step(input logic st, input logic rd);
    @(negedge clk);
    start = st;
    bus.win_ready = rd;
    #1;
    mon();
    cyc++;
  endtask

  // mode 0: ready=1 with stray starts in RUN/DRAIN; 1: 10-cycle stall;
  // 2: random ready; 3: stop after 500 taps for the reset test.
  task automatic run_frame(input int mode);
    int guard;
    logic st, rd;
    frame_init();
    guard = 0;
    step(1'b1, 1'b1);
    while (!(done_cyc >= 0 && cyc > done_cyc + 2) && guard < 4000) begin
      if (mode == 3 && nhs >= 500) break;
      st = (mode == 0) && (cyc == 500 || cyc == 1297);
      rd = 1'b1;
      if (mode == 1) rd = !(cyc >= 400 && cyc <= 409);
      if (mode == 2) rd = 1'($urandom_range(0, 1));
      stall_win = (mode == 1) && (cyc >= 400 && cyc <= 409);
      step(st, rd);
      guard++;
    end
    chk("frame_timeout", 256'(guard < 4000), 256'(1));
  endtask

  task automatic check_basic();
    chk("handshakes", 256'(nhs), 256'(1296));
    chk("strobes", 256'(nstb), 256'(1296));
    chk("last_count", 256'(nlast), 256'(1));
    chk("done_pulses", 256'(ndone), 256'(1));
    chk("max_outstanding_le2", 256'(max_out <= 2), 256'(1));
    chk("idle_after_done", 256'({busy, bus.win_valid}), 256'(0));
  endtask

  task automatic check_timing();
    chk("first_strobe", 256'(first_stb), 256'(1));
    chk("last_strobe", 256'(last_stb), 256'(1296));
    chk("first_valid", 256'(first_val), 256'(3));
    chk("done_cycle", 256'(done_cyc), 256'(1299));
    chk("busy_first", 256'(first_busy), 256'(1));
    chk("busy_last", 256'(last_busy), 256'(1298));
  endtask

  task automatic check_table();
    for (int i = 0; i < 10; i++) begin
      chk("order", 256'({rec_pr[tbl[i].tap], rec_pc[tbl[i].tap], rec_k[tbl[i].tap]}),
          256'({tbl[i].prow, tbl[i].pcol, tbl[i].kidx}));
      chk("order_data", 256'(rec_d[tbl[i].tap]), 256'(tbl[i].prow * 14 + tbl[i].pcol));
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0}; tbl[1] = '{1, 0, 1, 1}; tbl[2] = '{2, 0, 2, 2};
    tbl[3] = '{3, 1, 0, 3}; tbl[4] = '{4, 1, 1, 4}; tbl[5] = '{5, 1, 2, 5};
    tbl[6] = '{6, 2, 0, 6}; tbl[7] = '{7, 2, 1, 7}; tbl[8] = '{8, 2, 2, 8};
    tbl[9] = '{9, 0, 1, 0};
    frame_init();
    rst = 1'b0; start = 1'b0; bus.win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_side", 256'({bus.layer3_result_read_signal, bus.read_row_addr, bus.read_col_addr}), 256'(0));
    chk("reset_win_side", 256'(cur_tap()), 256'(0));
    chk("reset_ctrl", 256'({bus.win_valid, busy, frame_done}), 256'(0));
    @(negedge clk) rst = 1'b1;

    run_frame(0);
    check_basic(); check_timing(); check_table();

    run_frame(1);
    check_basic();
    chk("stall_strobes_le2", 256'(stall_stb <= 2), 256'(1));

    run_frame(2);
    check_basic();

    run_frame(3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_side", 256'({bus.layer3_result_read_signal, bus.read_row_addr, bus.read_col_addr}), 256'(0));
    chk("midrst_win_side", 256'(cur_tap()), 256'(0));
    chk("midrst_ctrl", 256'({bus.win_valid, busy, frame_done}), 256'(0));
    repeat (4) step(1'b0, 1'b1);
    chk("midrst_no_done", 256'(ndone), 256'(0));
    @(negedge clk) rst = 1'b1;

    run_frame(0);
    check_basic(); check_timing(); check_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer4_window_fetch.md
Name: layer4_window_fetch

Overview:
- Downstream consumer of the layer-3 result memory.
- Generates read addresses and read strobes into that memory, then captures the returned 128-bit pixel words (8 channels x 16 bit).
- Streams them to the layer-4 convolution MAC one kernel tap at a time, with a valid/ready handshake.
- Sweeps every KERNEL x KERNEL window of the MAP_WIDTH x MAP_WIDTH layer-3 feature map, stride 1, and signals frame completion.

Parameters:
- MAP_WIDTH, 14, rows/columns of layer-3 result map.
- KERNEL, 3, layer-4 kernel edge.
- DATA_WIDTH, 128, pixel word width (`LAYER3_OUTPUT_LENGTH).
- FIFO_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset; rst==0 clears all state immediately.
- start  in  1  one-cycle pulse; begins a frame sweep when idle.
- read_row_addr  out  16  row address to result memory.
- read_col_addr  out  16  column address to result memory.
- layer3_result_read_signal  out  1  read strobe to result memory.
- layer3_result_output  in  DATA_WIDTH  result memory read data, valid one cycle after strobe.
- win_data  out  DATA_WIDTH  current tap pixel word.
- win_valid  out  1  win_data/tags valid.
- win_ready  in  1  MAC accepts the tap.
- win_kidx  out  4  tap index, 0..KERNEL*KERNEL-1, computed as k_r*KERNEL+k_c.
- win_row  out  16  window origin row.
- win_col  out  16  window origin column.
- win_last  out  1  last tap of the last window of the frame.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse after final handshake.

Behaviour:
- Reset: all outputs 0.
  - State IDLE.
  - Counters, FIFO and in-flight flag cleared.
  - Applies mid-frame too; the partial frame is abandoned and no frame_done is issued.
- FSM: IDLE -> RUN on start.
  - RUN -> DRAIN in the cycle after the last address issues.
  - DRAIN -> DONE when FIFO empty and nothing in flight.
  - DONE -> IDLE unconditionally. frame_done=1 only in DONE.
  - start outside IDLE is ignored.
- Counters and issue order: k_c fastest, then k_r, then win_col, then win_row.
  - k_r, k_c range 0..KERNEL-1.
  - win_row, win_col range 0..MAP_WIDTH-KERNEL.
  - Addresses: read_row_addr=win_row+k_r, read_col_addr=win_col+k_c, zero-extended to 16 bits.
  - Defaults: 14x14 map gives 12x12=144 windows x 9 taps = 1296 reads per frame.
  - Counters wrap to 0 after their maximum; the final wrap of win_row ends issuing.
- Read issue (RUN only) happens when (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = win_valid & win_ready in the same cycle.
  - On issue, the strobe is 1 and the addresses are driven that cycle.
  - Otherwise the strobe is 0 and the addresses hold their last value.
- Latency: data for a strobe in cycle N is sampled from layer3_result_output at posedge ending cycle N+1.
  - It is written into the FIFO together with its tags (kidx, row, col, last).
  - The earliest win_valid is cycle N+2.
  - A single-bit inflight flag tracks the outstanding read.
- FIFO: 2 entries.
  - Head drives win_* outputs registered.
  - win_valid = FIFO non-empty.
  - win_data and tags stable while win_valid & !win_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - Overflow is impossible by the issue rule.
- Throughput: with win_ready held 1, one tap per cycle.
  - start at cycle 0; strobes cycles 1..1296; win_valid cycles 3..1298.
  - DRAIN entered cycle 1297; DONE/frame_done cycle 1299, when FIFO is empty and nothing is in flight; busy=1 cycles 1..1298.
- win_last is set on the tag of the tap with win_row=win_col=MAP_WIDTH-KERNEL and kidx=KERNEL*KERNEL-1.

Test Plan:
- Ordering: start, win_ready=1 -> first 10 taps are (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0),(2,1),(2,2),(0,1), with kidx 0..8 then 0.
  - Data equals a memory model preloaded with value row*14+col in every channel.
- Full frame, ready=1 -> exactly 1296 handshakes and 1296 strobes.
  - win_last only on the 1296th, which has (row=11, col=11, kidx=8).
  - frame_done single pulse at cycle 1299; busy low afterwards.
- Backpressure: win_ready=0 for 10 cycles mid-frame -> at most 2 strobes during the stall.
  - win_data and tags are frozen; no tap is lost or duplicated; sequence resumes correctly.
- Random win_ready (50%) over a full frame -> 1296 ordered taps matching the scoreboard.
  - The FIFO count never exceeds 2.
- start pulsed during RUN and DRAIN -> ignored.
  - Exactly one frame_done; a second frame started after DONE repeats an identical sequence.
- rst=0 asserted at tap 500 -> all outputs 0 immediately with no frame_done.
  - After release plus start, the first tap is again (0,0) with kidx 0.
